// File: rtl/cordic_angle_seq.sv
// cordic_angle_seq: CORDIC iteration sequencer and angle accumulator.
// Drives the running angle to the angle comparator, consumes its registered
// lt/gt result, adds or subtracts the atan entry and records the direction history.
// Optional comparator consistency check: define CORDIC_CMP_CHECK_EN.
module cordic_angle_seq #(
  parameter int unsigned N_ITER = 6,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned ANG_W  = 6
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              lt,
  input  logic              gt,
  input  logic [ANG_W-1:0]  atan_val,
  output logic [ADDR_W-1:0] atan_addr,
  output logic [ANG_W-1:0]  acc,
  output logic              dir,
  output logic [N_ITER-1:0] dir_hist,
  output logic              busy,
  output logic              done,
  output logic              cmp_err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_ROTATE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [ANG_W-1:0]    r_acc;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_dir;
  logic [N_ITER-1:0]   r_hist;
  logic                r_busy;
  logic                r_done;

  state_t              w_state_nxt;
  logic [ANG_W-1:0]    w_acc_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic                w_dir_nxt;
  logic [N_ITER-1:0]   w_hist_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

`ifdef CORDIC_CMP_CHECK_EN
  logic                r_err;
  logic                w_err_nxt;
`else
  logic                w_unused_lt;
  assign w_unused_lt = lt;
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; rotation direction follows gt only
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_addr_nxt  = r_addr;
    w_dir_nxt   = r_dir;
    w_hist_nxt  = r_hist;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
`ifdef CORDIC_CMP_CHECK_EN
    w_err_nxt   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_acc_nxt   = '0;
          w_addr_nxt  = '0;
          w_hist_nxt  = '0;
          w_busy_nxt  = 1'b1;
`ifdef CORDIC_CMP_CHECK_EN
          w_err_nxt   = 1'b0;
`endif
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_state_nxt = S_ROTATE;
      end
      S_ROTATE: begin
        w_dir_nxt = gt;
        w_acc_nxt = gt ? (r_acc - atan_val) : (r_acc + atan_val);
        for (int unsigned i = 0; i < N_ITER; i++) begin
          if (r_addr == ADDR_W'(i)) begin
            w_hist_nxt[i] = gt;
          end
        end
`ifdef CORDIC_CMP_CHECK_EN
        if (lt == gt) begin
          w_err_nxt = 1'b1;
        end
`endif
        if (r_addr == LAST_ADDR) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_addr_nxt  = r_addr + ADDR_W'(1);
          w_state_nxt = S_SETTLE;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_acc  <= '0;
      r_addr <= '0;
      r_dir  <= 1'b0;
      r_hist <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_addr <= w_addr_nxt;
      r_dir  <= w_dir_nxt;
      r_hist <= w_hist_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

`ifdef CORDIC_CMP_CHECK_EN
  // Sticky comparator consistency flag, cleared by reset or an accepted start
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err_nxt;
    end
  end
  assign cmp_err = r_err;
`else
  assign cmp_err = 1'b0;
`endif

  assign atan_addr = r_addr;
  assign acc       = r_acc;
  assign dir       = r_dir;
  assign dir_hist  = r_hist;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_cordic_angle_seq.sv
// tb_cordic_angle_seq: self-checking bench for cordic_angle_seq with a
// registered comparator model, an operation-level reference model and
// directed plus randomized stimulus.
module tb_cordic_angle_seq;

  localparam int unsigned N_ITER = 6;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned ANG_W  = 6;
`ifdef CORDIC_CMP_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              CLK   = 1'b0;
  logic              RST_N = 1'b1;
  logic              start = 1'b0;
  logic              lt;
  logic              gt;
  logic [ANG_W-1:0]  atan_val;
  logic [ADDR_W-1:0] atan_addr;
  logic [ANG_W-1:0]  acc;
  logic              dir;
  logic [N_ITER-1:0] dir_hist;
  logic              busy;
  logic              done;
  logic              cmp_err;

  cordic_angle_seq #(.N_ITER(N_ITER), .ADDR_W(ADDR_W), .ANG_W(ANG_W)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .lt(lt), .gt(gt),
    .atan_val(atan_val), .atan_addr(atan_addr), .acc(acc), .dir(dir),
    .dir_hist(dir_hist), .busy(busy), .done(done), .cmp_err(cmp_err)
  );

  always #5 CLK = ~CLK;

  // Environment: atan ROM, target angle, optional forced lt=gt=1 iteration
  logic [ANG_W-1:0] rom [0:7];
  logic [ANG_W-1:0] target = '0;
  int               inj = -1;
  logic             cmp_lt = 1'b0;
  logic             cmp_gt = 1'b0;

  assign atan_val = rom[atan_addr];
  assign lt = cmp_lt;
  assign gt = cmp_gt;

  // Registered comparator, one cycle behind acc
  always @(posedge CLK) begin
    if (inj >= 0 && int'(atan_addr) == inj) begin
      cmp_lt <= 1'b1;
      cmp_gt <= 1'b1;
    end else begin
      cmp_gt <= (acc > target);
      cmp_lt <= (acc <= target);
    end
  end

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: whole-operation result computed at acceptance, then
  // revealed one iteration per two clock edges after acceptance
  logic [ANG_W-1:0]  s_acc [0:N_ITER-1];
  logic              s_dir [0:N_ITER-1];
  logic              s_err [0:N_ITER-1];
  bit                m_active = 1'b0;
  int                m_k = 0;
  logic [ANG_W-1:0]  e_acc = '0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic              e_dir = 1'b0;
  logic [N_ITER-1:0] e_hist = '0;
  logic              e_busy = 1'b0;
  logic              e_done = 1'b0;
  logic              e_err = 1'b0;

  task automatic model_compute();
    logic [ANG_W-1:0] a;
    logic g;
    a = '0;
    for (int j = 0; j < int'(N_ITER); j++) begin
      g = (j == inj) || (a > target);
      s_dir[j] = g;
      s_err[j] = (j == inj);
      a = g ? (a - rom[j]) : (a + rom[j]);
      s_acc[j] = a;
    end
  endtask

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_active = 1'b0; m_k = 0;
      e_acc = '0; e_addr = '0; e_dir = 1'b0; e_hist = '0;
      e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
    end else if (!m_active) begin
      e_done = 1'b0;
      if (start) begin
        m_active = 1'b1; m_k = 0;
        e_acc = '0; e_addr = '0; e_hist = '0; e_busy = 1'b1; e_err = 1'b0;
        model_compute();
      end
    end else begin
      m_k++;
      if (m_k >= 2 && m_k <= 2 * int'(N_ITER) && (m_k % 2) == 0) begin
        int j;
        j = m_k / 2 - 1;
        e_acc = s_acc[j];
        e_dir = s_dir[j];
        e_hist[j] = s_dir[j];
        if (s_err[j]) e_err = 1'b1;
        if (j < int'(N_ITER) - 1) e_addr = ADDR_W'(j + 1);
      end
      e_done = (m_k == 2 * int'(N_ITER));
      if (m_k == 2 * int'(N_ITER) + 1) begin
        m_active = 1'b0;
        e_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge CLK) begin
    if (chk_on) begin
      chk("acc", 32'(acc), 32'(e_acc));
      chk("atan_addr", 32'(atan_addr), 32'(e_addr));
      chk("dir", 32'(dir), 32'(e_dir));
      chk("dir_hist", 32'(dir_hist), 32'(e_hist));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("cmp_err", 32'(cmp_err), 32'(CHK_EN ? e_err : 1'b0));
    end
  end

  // Logged single-operation runner; called at #1 after an edge with DUT idle
  logic [ANG_W-1:0] log_acc [0:30];
  logic             log_dir [0:30];
  logic             log_err [0:30];
  int done_cnt, done_e1, done_e2, busy_cnt;

  task automatic run_logged(input int hold_until);
    done_cnt = 0; done_e1 = -1; done_e2 = -1; busy_cnt = 0;
    start = 1'b1;
    for (int e = 0; e <= 30; e++) begin
      @(posedge CLK); #1;
      if (e >= hold_until) start = 1'b0;
      log_acc[e] = acc; log_dir[e] = dir; log_err[e] = cmp_err;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_e1 < 0) done_e1 = e; else done_e2 = e;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) begin
      @(posedge CLK); #1;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic set_nominal();
    rom[0] = 6'd32; rom[1] = 6'd19; rom[2] = 6'd10;
    rom[3] = 6'd5;  rom[4] = 6'd3;  rom[5] = 6'd1;
    rom[6] = 6'd0;  rom[7] = 6'd0;
    target = 6'd20;
  endtask

  initial begin
    int r;
    set_nominal();
    #1 RST_N = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK); #1;

    // Reset mid-operation with start held high
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1 RST_N = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_acc", 32'(acc), 32'(0));
    chk("rst_hist", 32'(dir_hist), 32'(0));
    chk("rst_addr", 32'(atan_addr), 32'(0));
    @(posedge CLK); #1;
    start = 1'b0; RST_N = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge CLK); #1;
      if (done || busy) done_cnt++;
    end
    chk("rst_no_done", 32'(done_cnt), 32'(0));

    // Nominal: target 20, ROM 32,19,10,5,3,1
    set_nominal(); inj = -1;
    run_logged(0);
    chk("nom_acc0", 32'(log_acc[2]), 32'(32));
    chk("nom_acc1", 32'(log_acc[4]), 32'(13));
    chk("nom_acc2", 32'(log_acc[6]), 32'(23));
    chk("nom_acc3", 32'(log_acc[8]), 32'(18));
    chk("nom_acc4", 32'(log_acc[10]), 32'(21));
    chk("nom_acc5", 32'(log_acc[12]), 32'(20));
    chk("nom_hist", 32'(dir_hist), 32'(6'b101010));
    chk("nom_done_edge", 32'(done_e1), 32'(12));
    chk("nom_busy_cycles", 32'(busy_cnt), 32'(13));
    chk("nom_done_cnt", 32'(done_cnt), 32'(1));
    chk("nom_hold_acc", 32'(acc), 32'(20));

    // Wrap-around: target 63, ROM all 40
    for (int i = 0; i < 8; i++) rom[i] = 6'd40;
    target = 6'd63;
    run_logged(0);
    chk("wrap_acc0", 32'(log_acc[2]), 32'(40));
    chk("wrap_acc1", 32'(log_acc[4]), 32'(16));
    chk("wrap_dir1", 32'(log_dir[4]), 32'(0));
    chk("wrap_err", 32'(log_err[30]), 32'(0));

    // start held through busy and the done cycle: ignored
    set_nominal();
    run_logged(13);
    chk("coinc_done_cnt", 32'(done_cnt), 32'(1));
    chk("coinc_busy_cycles", 32'(busy_cnt), 32'(13));

    // Back-to-back: start high in the first idle cycle after done
    run_logged(14);
    chk("b2b_done_cnt", 32'(done_cnt), 32'(2));
    chk("b2b_done2_edge", 32'(done_e2), 32'(26));
    chk("b2b_acc_clear", 32'(log_acc[14]), 32'(0));
    chk("b2b_final_acc", 32'(log_acc[26]), 32'(20));

    // Forced lt=gt=1 in iteration 3
    inj = 3;
    run_logged(0);
    chk("inj_err_before", 32'(log_err[7]), 32'(0));
    chk("inj_err_after", 32'(log_err[8]), 32'(CHK_EN));
    chk("inj_dir", 32'(log_dir[8]), 32'(1));
    chk("inj_err_done", 32'(log_err[12]), 32'(CHK_EN));
    inj = -1;
    run_logged(0);
    chk("inj_err_cleared", 32'(log_err[0]), 32'(0));
    wait_idle();

    // Randomized operations, random start traffic and rare resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      if (!m_active) begin
        for (int i = 0; i < 8; i++) rom[i] = ANG_W'($urandom_range(0, 63));
        target = ANG_W'($urandom_range(0, 63));
        r = int'($urandom_range(0, 11));
        inj = (r < int'(N_ITER)) ? r : -1;
      end
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
      end
    end
    start = 1'b0;
    wait_idle();
    @(negedge CLK);
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
